hilo_muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide engine that owns the HI/LO register pair.
- Replaces the single-cycle 64-bit ALU path and the standalone HI/LO register file in the execute stage.
- Accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO commands and produces a Busy signal for the hazard/stall logic.
- Publishes HI/LO for MFHI/MFLO reads.

---
 rtl/hilo_muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine owning the HI/LO pair: radix-2 shift-add multiply,
// restoring divide, one bit per cycle, plus MTHI/MTLO writes and a Busy flag for stall logic.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, nextState;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     operand;
  logic                 isDiv, negRes, negRem, zeroDiv;
  logic [WIDTH-1:0]     hiReg, loReg;
  logic                 doneReg, divZeroReg;

  logic                 opSigned, opDiv, divByZero, lastIter;
  logic [WIDTH-1:0]     aMag, bMag;
  logic [WIDTH:0]       mulSum, remShift, remDiff;
  logic                 divFits;
  logic [2*WIDTH-1:0]   mulNext, divNext;
  logic [WIDTH-1:0]     fixHi, fixLo;

  assign opSigned  = ~Op[0];
  assign opDiv     = Op[1];
  assign divByZero = opDiv && (OperandB == '0);
  assign aMag      = (opSigned && OperandA[WIDTH-1]) ? -OperandA : OperandA;
  assign bMag      = (opSigned && OperandB[WIDTH-1]) ? -OperandB : OperandB;
  assign lastIter  = (cnt == CNT_W'(WIDTH-1));

  // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
  assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
  assign mulNext = {mulSum, acc[WIDTH-1:1]};

  // Divide: shift the next dividend bit into the remainder; the extra bit covers large divisors.
  assign remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign divFits  = remShift >= {1'b0, operand};
  assign remDiff  = remShift - {1'b0, operand};
  assign divNext  = {divFits ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0], acc[WIDTH-2:0], divFits};

  always_comb begin
    fixHi = acc[2*WIDTH-1:WIDTH];
    fixLo = acc[WIDTH-1:0];
    if (!zeroDiv) begin
      if (!isDiv) begin
        if (negRes) {fixHi, fixLo} = -acc;
      end else begin
        if (negRes) fixLo = -acc[WIDTH-1:0];
        if (negRem) fixHi = -acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (Start && !Flush && !Op[2]) nextState = divByZero ? FIX : CALC;
      CALC: if (Flush) nextState = IDLE; else if (lastIter) nextState = FIX;
      FIX:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= nextState;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt        <= '0;
      acc        <= '0;
      operand    <= '0;
      isDiv      <= 1'b0;
      negRes     <= 1'b0;
      negRem     <= 1'b0;
      zeroDiv    <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: if (Start && !Flush) begin
          if (Op == 3'b100) begin
            hiReg      <= OperandA;
            divZeroReg <= 1'b0;
          end else if (Op == 3'b101) begin
            loReg      <= OperandA;
            divZeroReg <= 1'b0;
          end else if (!Op[2]) begin
            divZeroReg <= 1'b0;
            cnt        <= '0;
            isDiv      <= opDiv;
            negRes     <= opSigned && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
            negRem     <= opSigned && OperandA[WIDTH-1];
            zeroDiv    <= divByZero;
            operand    <= opDiv ? bMag : aMag;
            // Divide-by-zero preloads the final raw Hi/Lo so FIX only has to write them back.
            if (divByZero) acc <= {OperandA, {WIDTH{1'b1}}};
            else           acc <= {{WIDTH{1'b0}}, opDiv ? aMag : bMag};
          end
        end
        CALC: if (!Flush) begin
          cnt <= cnt + CNT_W'(1);
          acc <= isDiv ? divNext : mulNext;
        end
        FIX: if (!Flush) begin
          hiReg   <= fixHi;
          loReg   <= fixLo;
          doneReg <= 1'b1;
          if (zeroDiv) divZeroReg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy    = (state != IDLE);
  assign Done    = doneReg;
  assign DivZero = divZeroReg;
  assign Hi      = hiReg;
  assign Lo      = loReg;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected HI/LO/DivZero/Done-cycle queued at issue,
// popped and compared by an independent monitor whenever Done is seen.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic          Clk = 1'b0, Rst = 1'b0, Start = 1'b0, Flush = 1'b0;
  logic [2:0]    Op = '0;
  logic [W-1:0]  OperandA = '0, OperandB = '0;
  logic          Busy, Done, DivZero;
  logic [W-1:0]  Hi, Lo;

  int compared = 0, mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           doneCyc;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] mHi = '0, mLo = '0;
  logic         mDz = 1'b0;

  hilo_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .OperandA(OperandA), .OperandB(OperandB),
    .Flush(Flush), .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; SV signed / and % truncate toward zero, remainder follows dividend.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    e.doneCyc = 0;
    e.hi = '0;
    e.lo = '0;
    case (op)
      3'b000: begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
      3'b001: begin p = 64'(a) * 64'(b); e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == '0) begin
          e.hi = a; e.lo = '1; e.dz = 1'b1;
        end else if (op == 3'b010) begin
          q = sa / sb; r = sa % sb;
          e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge Clk) begin
    if (Rst && Done) begin
      if (sbq.size() == 0) check("unexpectedDone", 64'(Done), 64'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        check("doneHi", 64'(Hi), 64'(e.hi));
        check("doneLo", 64'(Lo), 64'(e.lo));
        check("doneDivZero", 64'(DivZero), 64'(e.dz));
        check("doneCycle", 64'(cyc), 64'(e.doneCyc));
      end
    end
  end

  task automatic accept(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic runOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int n;
    accept(op, a, b);
    e = model(op, a, b);
    e.doneCyc = cyc + (e.dz ? 1 : W + 1);
    sbq.push_back(e);
    n = 0;
    repeat (200) begin
      @(negedge Clk);
      if (!Busy) break;
      n++;
    end
    check("busyCycles", 64'(n), e.dz ? 64'd1 : 64'(W + 1));
    mHi = e.hi; mLo = e.lo; mDz = e.dz;
    check("hiAfterOp", 64'(Hi), 64'(mHi));
    check("loAfterOp", 64'(Lo), 64'(mLo));
  endtask

  task automatic mtOp(input logic [2:0] op, input logic [W-1:0] a);
    accept(op, a, '0);
    if (op == 3'b100) mHi = a; else mLo = a;
    mDz = 1'b0;
    @(negedge Clk);
    check("mtHi", 64'(Hi), 64'(mHi));
    check("mtLo", 64'(Lo), 64'(mLo));
    check("mtBusy", 64'(Busy), 64'd0);
    check("mtDivZero", 64'(DivZero), 64'd0);
  endtask

  task automatic checkHeld(input string name);
    check({name, "Hi"}, 64'(Hi), 64'(mHi));
    check({name, "Lo"}, 64'(Lo), 64'(mLo));
    check({name, "DivZero"}, 64'(DivZero), 64'(mDz));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge Clk);
    check("rstHi", 64'(Hi), 64'd0);
    check("rstLo", 64'(Lo), 64'd0);
    check("rstBusy", 64'(Busy), 64'd0);
    check("rstDone", 64'(Done), 64'd0);
    check("rstDivZero", 64'(DivZero), 64'd0);
    Rst = 1'b1;

    runOp(3'b000, 32'hFFFFFFFD, 32'd5);
    runOp(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    runOp(3'b010, 32'hFFFFFFF9, 32'd2);
    runOp(3'b011, 32'd100, 32'd7);
    runOp(3'b011, 32'h12345678, 32'd0);
    runOp(3'b000, 32'd3, 32'd4);
    runOp(3'b010, 32'h80000000, 32'hFFFFFFFF);
    runOp(3'b010, 32'h00000007, 32'h00000000);
    runOp(3'b011, 32'hFFFFFFFF, 32'h80000001);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a, b;
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      runOp(op, a, b);
    end

    mtOp(3'b100, 32'h1234ABCD);
    mtOp(3'b101, 32'h0F0F0F0F);

    // Start while busy is ignored, then Flush in CALC aborts without writeback.
    accept(3'b000, 32'd123, 32'd456);
    repeat (4) @(negedge Clk);
    Start = 1'b1; Op = 3'b100; OperandA = 32'h5555AAAA;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    check("busyMidCalc", 64'(Busy), 64'd1);
    checkHeld("mthiWhileBusy");
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    check("flushCalcBusy", 64'(Busy), 64'd0);
    repeat (3) @(negedge Clk);
    checkHeld("flushCalc");
    mtOp(3'b101, 32'hCAFEF00D);

    // Flush during the FIX cycle beats the writeback.
    accept(3'b011, 32'd1000, 32'd3);
    repeat (W + 1) @(negedge Clk);
    check("busyInFix", 64'(Busy), 64'd1);
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    check("flushFixBusy", 64'(Busy), 64'd0);
    repeat (3) @(negedge Clk);
    checkHeld("flushFix");

    // Flush in IDLE blocks a same-cycle Start; Op 11x is a no-op.
    @(negedge Clk);
    Start = 1'b1; Op = 3'b100; OperandA = 32'hDEADBEEF; Flush = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; Flush = 1'b0;
    @(negedge Clk);
    checkHeld("flushIdle");
    accept(3'b110, 32'hDEADBEEF, 32'd9);
    @(negedge Clk);
    check("noopBusy", 64'(Busy), 64'd0);
    checkHeld("noop");

    // Asynchronous reset between edges mid-CALC.
    accept(3'b000, 32'd77, 32'd88);
    repeat (10) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    check("asyncRstBusy", 64'(Busy), 64'd0);
    check("asyncRstHi", 64'(Hi), 64'd0);
    check("asyncRstLo", 64'(Lo), 64'd0);
    mHi = '0; mLo = '0; mDz = 1'b0;
    @(negedge Clk);
    Rst = 1'b1;
    runOp(3'b000, 32'd6, 32'd7);

    repeat (5) @(negedge Clk);
    check("scoreboardDrained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
